// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_HALT,
    S_ERR
  } state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words; a last byte mid-word
// zero-pads the remaining low bytes and emits the word early.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         data,
  input  logic               last,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);
  logic [1:0]         idx;
  logic [INSTR_W-1:0] shifted;

  assign shifted = {word[INSTR_W-9:0], data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 2'd0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      idx        <= 2'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= accept && (last || idx == 2'(BYTES_PER_WORD - 1));
      if (accept) begin
        idx <= last ? 2'd0 : idx + 2'd1;
        // Older bytes fall off the top; on last, shift the partial word into place.
        word <= last ? (shifted << {2'd3 - idx, 3'b000}) : shifted;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Program-load front end: packs a byte stream into instruction memory,
// then pulses a PC reset and enables fetch until halted or reloaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic               start_req,
  input  logic               halt_in,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               pc_rst,
  output logic               run,
  output logic [ADDR_W:0]    word_count,
  output logic               err
);
  state_t             state, state_next;
  logic               draining;
  logic [ADDR_W:0]    wcount;
  logic               word_valid;
  logic [INSTR_W-1:0] word;
  logic               fire, full, overflow, accept, clear;

  assign fire = in_valid && in_ready;
  // Full also covers the cycle in which the final slot is being written.
  assign full = (wcount == (ADDR_W+1)'(DEPTH)) ||
                (word_valid && wcount == (ADDR_W+1)'(DEPTH - 1));
  assign overflow = fire && full;
  assign accept   = fire && !full;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .data       (in_data),
    .last       (in_last),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: if (load_req) begin
        state_next = S_LOAD;
        clear      = 1'b1;
      end
      S_LOAD: begin
        in_ready = !draining;
        if (overflow)                    state_next = S_ERR;
        else if (draining && word_valid) state_next = S_START;
      end
      S_START: state_next = S_RUN;
      S_RUN: begin
        if (load_req) begin
          state_next = S_LOAD;
          clear      = 1'b1;
        end else if (halt_in) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (load_req) begin
          state_next = S_LOAD;
          clear      = 1'b1;
        end else if (start_req) begin
          state_next = S_START;
        end
      end
      S_ERR: if (load_req) begin
        state_next = S_LOAD;
        clear      = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered control outputs and load bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcount   <= '0;
      draining <= 1'b0;
      err      <= 1'b0;
      pc_rst   <= 1'b0;
      run      <= 1'b0;
    end else begin
      pc_rst <= (state_next == S_START);
      run    <= (state_next == S_RUN);
      if (clear) begin
        wcount   <= '0;
        draining <= 1'b0;
        err      <= 1'b0;
      end else begin
        if (word_valid)         wcount   <= wcount + 1'b1;
        if (accept && in_last)  draining <= 1'b1;
        if (overflow)           err      <= 1'b1;
      end
    end
  end

  assign imem_we    = word_valid;
  assign imem_addr  = wcount[ADDR_W-1:0];
  assign imem_wdata = word;
  assign word_count = wcount;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized loads against a byte-list packing model.
module tb_imem_loader;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, load_req, start_req, halt_in;
  logic              in_valid, in_last, in_ready;
  logic [7:0]        in_data;
  logic              imem_we, pc_rst, run, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .start_req  (start_req),
    .halt_in    (halt_in),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .pc_rst     (pc_rst),
    .run        (run),
    .word_count (word_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_and_check(input string tag, input logic [7:0] bq[$],
                                input bit last_on_end, input bit gaps);
    int n = bq.size();
    int nw = (n + 3) / 4;
    int exp_words;
    int t = 0;
    logic [31:0] ew[$];
    for (int i = 0; i < nw; i++) ew.push_back(32'h0);
    for (int i = 0; i < n; i++) ew[i/4] |= 32'(bq[i]) << (24 - 8 * (i % 4));
    exp_words = (nw > DEPTH) ? DEPTH : nw;

    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_load();
    chk({tag, "_ready"}, in_ready, 1'b1);
    chk({tag, "_run_low"}, run, 1'b0);
    for (int i = 0; i < n; i++) send(bq[i], last_on_end && (i == n - 1), gaps);

    if (last_on_end) begin
      while (!pc_rst && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk({tag, "_pc_rst"}, pc_rst, 1'b1);
      chk({tag, "_start_run"}, run, 1'b0);
      @(negedge clk);
      chk({tag, "_pc_rst_one"}, pc_rst, 1'b0);
      chk({tag, "_run"}, run, 1'b1);
    end else begin
      repeat (2) @(negedge clk);
    end

    chk({tag, "_nwrites"}, wr_addr_q.size(), exp_words);
    for (int i = 0; i < exp_words && i < wr_addr_q.size(); i++) begin
      chk({tag, "_addr"}, wr_addr_q[i], i);
      chk({tag, "_data"}, wr_data_q[i], ew[i]);
    end
    chk({tag, "_word_count"}, word_count, exp_words);
    chk({tag, "_err"}, err, (n > 4 * DEPTH) ? 1'b1 : 1'b0);
  endtask

  initial begin
    logic [7:0] bq[$];
    int n;

    rst = 1'b1; load_req = 1'b0; start_req = 1'b0; halt_in = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_run", run, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_pc_rst", pc_rst, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_wc", word_count, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1'b0);

    bq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
    load_and_check("basic", bq, 1'b1, 1'b0);

    // Halt then restart: no writes, counters held.
    wr_addr_q.delete();
    wr_data_q.delete();
    halt_in = 1'b1;
    @(negedge clk);
    halt_in = 1'b0;
    chk("halt_run", run, 1'b0);
    chk("halt_pc_rst", pc_rst, 1'b0);
    @(negedge clk);
    chk("halt_stays", run, 1'b0);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    chk("restart_pc_rst", pc_rst, 1'b1);
    chk("restart_run_low", run, 1'b0);
    @(negedge clk);
    chk("restart_pc_rst_one", pc_rst, 1'b0);
    chk("restart_run", run, 1'b1);
    chk("restart_nwrites", wr_addr_q.size(), 0);
    chk("restart_wc_held", word_count, 2);

    bq = '{8'hAA, 8'hBB};
    load_and_check("partial", bq, 1'b1, 1'b0);

    bq = '{8'h5C};
    load_and_check("single", bq, 1'b1, 1'b0);

    // load_req beats halt_in; then async reset mid-word.
    wr_addr_q.delete();
    wr_data_q.delete();
    load_req = 1'b1;
    halt_in  = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    halt_in  = 1'b0;
    chk("prio_run", run, 1'b0);
    chk("prio_ready", in_ready, 1'b1);
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", imem_we, 1'b0);
    chk("arst_run", run, 1'b0);
    chk("arst_ready", in_ready, 1'b0);
    chk("arst_pc_rst", pc_rst, 1'b0);
    chk("arst_wc", word_count, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_wdata", imem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_nwrites", wr_addr_q.size(), 0);

    // Backpressure gaps and randomized program lengths.
    for (int k = 0; k < 8; k++) begin
      n = (k == 0) ? 8 : $urandom_range(1, 4 * DEPTH);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
      load_and_check("rand", bq, 1'b1, 1'b1);
    end

    // Overflow: 17 bytes without last into a 4-word memory.
    bq.delete();
    for (int i = 0; i < 4 * DEPTH + 1; i++) bq.push_back(8'($urandom_range(0, 255)));
    load_and_check("ovf", bq, 1'b0, 1'b0);
    chk("ovf_ready", in_ready, 1'b0);
    chk("ovf_run", run, 1'b0);
    chk("ovf_err_sticky", err, 1'b1);
    pulse_load();
    chk("ovf_clear_err", err, 1'b0);
    chk("ovf_reload_ready", in_ready, 1'b1);
    chk("ovf_reload_wc", word_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program-load front end sitting directly upstream of the instruction-fetch stage; implements the "code" mode of the core.
- Accepts a byte stream over a valid/ready handshake and packs it MSB-first into 32-bit instruction words, writing them into instruction memory from address 0.
- Then pulses a PC reset and holds the fetch stage in "execute" mode (run) until halted or reloaded.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 1024, number of instruction words; must equal 2**ADDR_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_req  in  1  one-cycle request to enter load mode.
- start_req  in  1  one-cycle request to re-run the loaded program from HALT.
- halt_in  in  1  halt indication from the pipeline.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  stream byte.
- in_last  in  1  marks the final byte of the program; qualified by in_valid.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  packed instruction word.
- pc_rst  out  1  one-cycle pulse forcing the fetch PC to 0.
- run  out  1  fetch enable; the pipeline advances only while high.
- word_count  out  ADDR_W+1  number of words written by the most recent load; held until the next load starts.
- err  out  1  load error (overflow); sticky until the next load_req.

Behaviour:
- Byte transfer: a byte is accepted on any clk edge where in_valid and in_ready are both high.
- Reset (async): state IDLE; all outputs 0; byte index, address counter and word register cleared. Reset mid-load discards the partial word. Memory contents are not touched.
- States: IDLE, LOAD, START, RUN, HALT, ERR.
- IDLE:
  - run=0, in_ready=0.
  - load_req -> LOAD; clears the address counter, byte index, word_count and err.
- LOAD: in_ready=1 combinationally.
  - Each accepted byte shifts into the word register (first byte lands in bits 31:24). The byte index counts 0..3.
  - On accepting byte index 3: next cycle imem_we=1, with imem_addr = current address and imem_wdata = the packed word. Then the address increments and word_count increments.
  - in_last on byte index 3: the write proceeds as normal, then the state goes to START.
  - in_last on byte index 0..2: the remaining low bytes are zero-padded, the word is written the next cycle, then START.
  - Overflow: a byte accepted after the word at address DEPTH-1 has been written is dropped (no write). err=1 and the state goes to ERR.
  - load_req and start_req are ignored.
  - in_ready stays 1 during the write cycle, so back-to-back bytes are allowed (one byte per cycle sustained).
- START: pc_rst=1 for exactly one cycle, run=0, in_ready=0; next state RUN.
- RUN:
  - run=1.
  - halt_in -> HALT; run falls on the same edge.
  - load_req -> LOAD; run falls and the counters clear.
  - If load_req and halt_in arrive together, load_req wins.
- HALT:
  - run=0.
  - start_req -> START.
  - load_req -> LOAD; load_req has priority over start_req.
- ERR:
  - run=0, in_ready=0, err=1.
  - load_req -> LOAD and clears err.
- Output drive: imem_we is a registered single-cycle pulse and is never asserted outside LOAD or its trailing write cycle. pc_rst is registered.
- Empty load: a LOAD that receives in_last on the very first byte writes exactly one word (byte<<24) and sets word_count=1.
- word_count range: 0..DEPTH. The extra bit represents a full memory.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum (IDLE, LOAD, START, RUN, HALT, ERR).
  - BYTES_PER_WORD=4.
  - INSTR_W=32.
- One sub-module, byte_packer:
  - Contains the 2-bit byte index, 32-bit shift register and pad-on-last logic.
  - Produces word_valid (one-cycle pulse) and word.
  - Has inputs clear and accept.
- The top level holds the FSM, the address/word counters and the error flag.

Test Plan:
- Reset then load: load_req; stream 00 00 00 01, 10 20 30 40 (last on 40) with in_valid held high -> writes addr0=0x00000001 and addr1=0x10203040 on consecutive word boundaries; word_count=2; pc_rst pulses one cycle; run=1 on the next cycle.
- Partial word: load_req; stream AA BB (last on BB) -> single write addr0=0xAABB0000; word_count=1; START then RUN.
- Halt and restart: in RUN, assert halt_in -> run=0 on the same edge; start_req -> pc_rst pulse, run=1; no imem writes occur.
- Overflow: with DEPTH=4 (ADDR_W=2), stream 17 bytes without last -> 4 writes at addr 0..3; the 17th byte is dropped; err=1; state ERR; in_ready=0; load_req clears err.
- Priority and async reset: in RUN, assert load_req and halt_in together -> state LOAD, run=0. Then assert rst mid-word after 2 bytes -> all outputs 0 immediately; no write occurs; the following load starts at addr0.
- Backpressure gaps: random in_valid gaps while streaming 8 bytes -> same two words as a gap-free stream; bytes are never duplicated or lost.
